// File: rtl/pipeline_pkg.sv
// Shared encodings for the pipeline hazard controller: FSM states, operand-forward selects, PC register index.
// Pure declarations; no logic, no latency, no flow control.
package pipeline_pkg;

  typedef enum logic [1:0] {
    ST_RUN      = 2'b00,
    ST_LU_STALL = 2'b01,
    ST_MEM_HOLD = 2'b10,
    ST_FLUSH    = 2'b11
  } hcu_state_e;

  localparam logic [1:0] FWD_RF  = 2'b00;
  localparam logic [1:0] FWD_EX  = 2'b01;
  localparam logic [1:0] FWD_MEM = 2'b10;
  localparam logic [1:0] FWD_WB  = 2'b11;

  localparam int PC_REG_DEFAULT = 15;

endpackage

// File: rtl/fwd_select.sv
// Priority comparator for one ID operand: picks EX > MEM > WB > RF and flags a load-use hit in EX.
// Combinational, zero latency; no backpressure.
module fwd_select
  import pipeline_pkg::*;
#(
  parameter int REG_W  = 4,
  parameter int PC_REG = PC_REG_DEFAULT
) (
  input  logic             i_use,
  input  logic [REG_W-1:0] i_rs,
  input  logic [REG_W-1:0] i_ex_rd,
  input  logic [REG_W-1:0] i_mem_rd,
  input  logic [REG_W-1:0] i_wb_rd,
  input  logic             i_ex_rf_e,
  input  logic             i_mem_rf_e,
  input  logic             i_wb_rf_e,
  input  logic             i_ex_load,
  output logic [1:0]       o_fwd,
  output logic             o_lu_hazard
);

  logic w_valid;
  logic w_ex_hit;
  logic w_mem_hit;
  logic w_wb_hit;

  // The PC is read from its own path, so it never takes a forwarded value.
  assign w_valid   = i_use && (i_rs != REG_W'(PC_REG));
  assign w_ex_hit  = i_ex_rf_e  && (i_rs == i_ex_rd);
  assign w_mem_hit = i_mem_rf_e && (i_rs == i_mem_rd);
  assign w_wb_hit  = i_wb_rf_e  && (i_rs == i_wb_rd);

  always_comb begin
    o_fwd = FWD_RF;
    if (w_valid) begin
      if (w_ex_hit)       o_fwd = FWD_EX;
      else if (w_mem_hit) o_fwd = FWD_MEM;
      else if (w_wb_hit)  o_fwd = FWD_WB;
    end
  end

  assign o_lu_hazard = w_valid && w_ex_hit && i_ex_load;

endmodule

// File: rtl/hazard_control_unit.sv
// Hazard controller beside ID: operand forwarding, load-use stall, memory-wait freeze, branch flush.
// Outputs decode the next state (zero latency); mem_wait freezes all stages. Optional macro HAZARD_STATS_EN adds cycle counters.
module hazard_control_unit
  import pipeline_pkg::*;
#(
  parameter int REG_W  = 4,
  parameter int PC_REG = PC_REG_DEFAULT,
  parameter int CNT_W  = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [REG_W-1:0] id_ra,
  input  logic [REG_W-1:0] id_rb,
  input  logic [REG_W-1:0] id_rd,
  input  logic             id_use_a,
  input  logic             id_use_b,
  input  logic             id_use_d,
  input  logic [REG_W-1:0] ex_rd,
  input  logic [REG_W-1:0] mem_rd,
  input  logic [REG_W-1:0] wb_rd,
  input  logic             ex_rf_e,
  input  logic             mem_rf_e,
  input  logic             wb_rf_e,
  input  logic             ex_load,
  input  logic             branch_taken,
  input  logic             mem_wait,
  output logic [1:0]       fwd_a,
  output logic [1:0]       fwd_b,
  output logic [1:0]       fwd_d,
  output logic             enable_pc,
  output logic             enable_ifid,
  output logic             enable_back,
  output logic             nop_sel,
  output logic             flush_ifid,
  output logic [1:0]       state_o
`ifdef HAZARD_STATS_EN
  ,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt,
  output logic [CNT_W-1:0] hold_cnt
`endif
);

  hcu_state_e r_state;
  hcu_state_e w_next_state;

  logic [1:0] w_fwd_a;
  logic [1:0] w_fwd_b;
  logic [1:0] w_fwd_d;
  logic       w_lu_a;
  logic       w_lu_b;
  logic       w_lu_d;
  logic       w_lu_hazard;

  fwd_select #(.REG_W(REG_W), .PC_REG(PC_REG)) u_fwd_a (
    .i_use(id_use_a), .i_rs(id_ra),
    .i_ex_rd(ex_rd), .i_mem_rd(mem_rd), .i_wb_rd(wb_rd),
    .i_ex_rf_e(ex_rf_e), .i_mem_rf_e(mem_rf_e), .i_wb_rf_e(wb_rf_e),
    .i_ex_load(ex_load), .o_fwd(w_fwd_a), .o_lu_hazard(w_lu_a)
  );

  fwd_select #(.REG_W(REG_W), .PC_REG(PC_REG)) u_fwd_b (
    .i_use(id_use_b), .i_rs(id_rb),
    .i_ex_rd(ex_rd), .i_mem_rd(mem_rd), .i_wb_rd(wb_rd),
    .i_ex_rf_e(ex_rf_e), .i_mem_rf_e(mem_rf_e), .i_wb_rf_e(wb_rf_e),
    .i_ex_load(ex_load), .o_fwd(w_fwd_b), .o_lu_hazard(w_lu_b)
  );

  fwd_select #(.REG_W(REG_W), .PC_REG(PC_REG)) u_fwd_d (
    .i_use(id_use_d), .i_rs(id_rd),
    .i_ex_rd(ex_rd), .i_mem_rd(mem_rd), .i_wb_rd(wb_rd),
    .i_ex_rf_e(ex_rf_e), .i_mem_rf_e(mem_rf_e), .i_wb_rf_e(wb_rf_e),
    .i_ex_load(ex_load), .o_fwd(w_fwd_d), .o_lu_hazard(w_lu_d)
  );

  assign w_lu_hazard = w_lu_a || w_lu_b || w_lu_d;

  assign fwd_a = reset ? w_fwd_a : FWD_RF;
  assign fwd_b = reset ? w_fwd_b : FWD_RF;
  assign fwd_d = reset ? w_fwd_d : FWD_RF;

  // A repeated load-use hit right after a stall falls through to RUN rather than stalling twice.
  always_comb begin
    w_next_state = ST_RUN;
    enable_pc    = 1'b1;
    enable_ifid  = 1'b1;
    enable_back  = 1'b1;
    nop_sel      = 1'b0;
    flush_ifid   = 1'b0;

    if (!reset)                                         w_next_state = ST_RUN;
    else if (mem_wait)                                  w_next_state = ST_MEM_HOLD;
    else if (w_lu_hazard && (r_state != ST_LU_STALL))   w_next_state = ST_LU_STALL;
    else if (branch_taken && !w_lu_hazard)              w_next_state = ST_FLUSH;

    case (w_next_state)
      ST_MEM_HOLD: begin
        enable_pc   = 1'b0;
        enable_ifid = 1'b0;
        enable_back = 1'b0;
      end
      ST_LU_STALL: begin
        enable_pc   = 1'b0;
        enable_ifid = 1'b0;
        nop_sel     = 1'b1;
      end
      ST_FLUSH: begin
        flush_ifid  = 1'b1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) r_state <= ST_RUN;
    else        r_state <= w_next_state;
  end

  assign state_o = r_state;

`ifdef HAZARD_STATS_EN
  logic [CNT_W-1:0] r_stall_cnt;
  logic [CNT_W-1:0] r_flush_cnt;
  logic [CNT_W-1:0] r_hold_cnt;

  // Counters track the registered state, i.e. cycles actually spent there, and stick at all-ones.
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_stall_cnt <= '0;
      r_flush_cnt <= '0;
      r_hold_cnt  <= '0;
    end else begin
      if (r_state == ST_LU_STALL && r_stall_cnt != '1) r_stall_cnt <= r_stall_cnt + CNT_W'(1);
      if (r_state == ST_FLUSH    && r_flush_cnt != '1) r_flush_cnt <= r_flush_cnt + CNT_W'(1);
      if (r_state == ST_MEM_HOLD && r_hold_cnt  != '1) r_hold_cnt  <= r_hold_cnt  + CNT_W'(1);
    end
  end

  assign stall_cnt = r_stall_cnt;
  assign flush_cnt = r_flush_cnt;
  assign hold_cnt  = r_hold_cnt;
`else
  // Counter width only matters for the statistics build.
  if (CNT_W < 1) begin : g_cnt_w_unused
  end
`endif

endmodule

// File: doc/hazard_control_unit.md
Name: hazard_control_unit

Overview:
- Pipeline hazard controller for the 5-stage ARM-subset pipeline (IF, ID, EX, MEM, WB).
- Sits beside ID. Compares ID source registers (RA=instr[3:0], RB=instr[19:16], RD=instr[15:12]) with the EX/MEM/WB destinations.
- Drives: forwarding selects for the PA/PB/PD operand muxes, PC and IF/ID enables, the control-unit NOP-insertion select, and the IF/ID flush on taken branches.
- Contains a small state machine that sequences load-use stalls, data-memory wait holds and branch flushes.

Parameters:
- REG_W, 4, register-specifier width.
- PC_REG, 15, register index never forwarded (read from the PC path).
- CNT_W, 16, width of statistics counters (optional feature only).

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  synchronous, active-low reset.
- id_ra, id_rb, id_rd  in  4 each  ID source specifiers.
- id_use_a, id_use_b, id_use_d  in  1 each  source actually read by the ID instruction.
- ex_rd, mem_rd, wb_rd  in  4 each  destination specifiers in EX/MEM/WB.
- ex_rf_e, mem_rf_e, wb_rf_e  in  1 each  register-write enables per stage.
- ex_load  in  1  EX instruction is a load.
- branch_taken  in  1  condition handler resolved a taken B/BL in ID.
- mem_wait  in  1  data memory not ready; freeze the whole pipe.
- fwd_a, fwd_b, fwd_d  out  2 each  operand source select: 00=RF, 01=EX, 10=MEM, 11=WB.
- enable_pc  out  1  PC register enable.
- enable_ifid  out  1  IF/ID register enable.
- enable_back  out  1  ID/EX, EX/MEM, MEM/WB enable.
- nop_sel  out  1  CU-output mux select; 1 inserts a bubble into ID/EX.
- flush_ifid  out  1  synchronous clear of IF/ID on the next edge.
- state_o  out  2  current FSM state (debug).

Behaviour:
- Reset: while reset==0 at a clock edge, state←RUN. During reset all outputs take their RUN/no-hazard values: enables=1, nop_sel=0, flush_ifid=0, fwd_*=00.
- Forwarding (combinational, every state), per operand X in {a,b,d}:
  - fwd_X=00 when id_use_X=0 or id_rX==PC_REG.
  - Otherwise priority EX > MEM > WB. The first stage with rf_e=1 and rd==id_rX selects 01/10/11; none → 00.
  - An EX match with ex_load=1 still encodes 01 but also raises a load-use hazard.
- lu_hazard = ex_load & ex_rf_e & any used source (excluding PC_REG) equals ex_rd.
- FSM states (registered):
  - RUN=00: no freeze.
  - LU_STALL=01: one bubble cycle.
  - MEM_HOLD=10: full freeze.
  - FLUSH=11: one flush cycle.
- Transitions, evaluated in priority order at each edge:
  1. mem_wait=1 → MEM_HOLD.
  2. lu_hazard=1 and state≠LU_STALL → LU_STALL.
  3. branch_taken=1 and no lu_hazard → FLUSH.
  4. Otherwise → RUN.
- Outputs are decoded from next-state (same-cycle response, zero latency):
  - MEM_HOLD: enable_pc=enable_ifid=enable_back=0, nop_sel=0, flush_ifid=0.
  - LU_STALL: enable_pc=enable_ifid=0, enable_back=1, nop_sel=1.
  - FLUSH: enable_pc=1, enable_ifid=1, flush_ifid=1, nop_sel=0.
  - RUN: all enables 1, nop_sel=0, flush_ifid=0.
- LU_STALL lasts exactly one cycle: the load advances to MEM and the hazard clears. If it is still asserted (corrupt bench), the FSM returns to RUN rather than stalling again.
- Simultaneous events:
  - mem_wait masks everything. A branch_taken or lu_hazard seen during MEM_HOLD is re-evaluated after mem_wait drops.
  - lu_hazard and branch_taken together: stall wins; the branch is re-resolved next cycle with correct operands.
- Reset asserted mid-stall or mid-hold: state←RUN on that edge; no residual freeze.

Optional Feature:
- Macro HAZARD_STATS_EN.
- Defined:
  - Adds outputs stall_cnt, flush_cnt, hold_cnt [CNT_W-1:0].
  - Each counts cycles spent in LU_STALL, FLUSH and MEM_HOLD respectively.
  - Counters saturate at all-ones and clear on reset.
- Undefined: ports and counters are absent; behaviour is otherwise identical.

Decomposition:
- Shared package pipeline_pkg holds:
  - FSM state encodings (ST_RUN, ST_LU_STALL, ST_MEM_HOLD, ST_FLUSH).
  - Forward-select constants (FWD_RF, FWD_EX, FWD_MEM, FWD_WB).
  - PC_REG default.
- One natural sub-module, fwd_select: the pure combinational priority comparator for one operand, instantiated three times (a, b, d).

Test Plan:
- ID ADD R1,R2,R3 with ex_rd=2, mem_rd=2, both rf_e=1, ex_load=0 → fwd_a=01 (EX priority), no stall, state RUN.
- LDR R5 in EX (ex_load=1, ex_rd=5), ID uses RB=5 → one cycle enable_pc=enable_ifid=0, nop_sel=1; next cycle RUN with fwd_b=10.
- branch_taken=1 with no hazard → flush_ifid=1 for exactly one cycle, enable_pc=1, then RUN.
- mem_wait=1 for 3 cycles while branch_taken=1 → all enables 0 for 3 cycles; FLUSH on the cycle mem_wait drops.
- lu_hazard and branch_taken together → LU_STALL first, then FLUSH on the following cycle.
- reset=0 asserted during MEM_HOLD → next edge state_o=00, all enables 1; source id_ra=15 with ex_rd=15 → fwd_a=00.
